// File: rtl/dpram_pipe_if.sv
// Port bundle for dpram_pipe: two independent RAM ports plus the shared collision strobe.
// Reads have no back-pressure: every enabled access is accepted at the clock edge, and valid* is a one-cycle strobe.
interface dpram_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic              valida;
  logic              enb;
  logic              web;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dinb;
  logic [DATA_W-1:0] doutb;
  logic              validb;
  logic              collision;

  modport master (
    output ena, wea, addra, dina,
    output enb, web, addrb, dinb,
    input  douta, valida, doutb, validb, collision
  );

  modport slave (
    input  ena, wea, addra, dina,
    input  enb, web, addrb, dinb,
    output douta, valida, doutb, validb, collision
  );
endinterface

// File: rtl/dpram_pipe.sv
// True dual-port synchronous RAM with 1- or 2-cycle read pipeline, per-port valid strobe,
// selectable read-during-write behaviour and a fixed winner for same-address write collisions.
module dpram_pipe #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int RD_LAT    = 1,
  parameter int WR_MODE   = 0,
  parameter int COLL_PRIO = 0
) (
  input logic         clk,
  input logic         rst_n,
  dpram_pipe_if.slave bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam bit WFIRST = (WR_MODE != 0);
  localparam bit B_WINS = (COLL_PRIO != 0);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("dpram_pipe: RD_LAT must be 1 or 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_a, wr_b, same_addr, both_wr;
  logic              commit_a, commit_b, coll_now;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  // Reads always see the pre-edge word unless the port itself writes in write-first mode,
  // so a cross-port reader never observes the other port's write in the same cycle.
  always_comb begin
    wr_a      = bus.ena & bus.wea;
    wr_b      = bus.enb & bus.web;
    same_addr = (bus.addra == bus.addrb);
    both_wr   = wr_a & wr_b & same_addr;
    commit_a  = wr_a & ~(both_wr & B_WINS);
    commit_b  = wr_b & ~(both_wr & ~B_WINS);
    rdata_a   = (wr_a & WFIRST) ? bus.dina : mem[bus.addra];
    rdata_b   = (wr_b & WFIRST) ? bus.dinb : mem[bus.addrb];
    coll_now  = bus.ena & bus.enb & same_addr & (bus.wea | bus.web);
  end

  logic [DATA_W-1:0] s1_da, s1_db;
  logic              s1_va, s1_vb;
  logic              coll_q;

  // The array is deliberately left out of the reset branch: contents survive reset,
  // and no write can happen on an edge while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_da  <= '0;
      s1_db  <= '0;
      s1_va  <= 1'b0;
      s1_vb  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      if (commit_a) mem[bus.addra] <= bus.dina;
      if (commit_b) mem[bus.addrb] <= bus.dinb;
      s1_va <= bus.ena;
      s1_vb <= bus.enb;
      if (bus.ena) s1_da <= rdata_a;
      if (bus.enb) s1_db <= rdata_b;
      coll_q <= coll_now;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_da, s2_db;
    logic              s2_va, s2_vb;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_da <= '0;
        s2_db <= '0;
        s2_va <= 1'b0;
        s2_vb <= 1'b0;
      end else begin
        s2_va <= s1_va;
        s2_vb <= s1_vb;
        if (s1_va) s2_da <= s1_da;
        if (s1_vb) s2_db <= s1_db;
      end
    end

    assign bus.douta  = s2_da;
    assign bus.valida = s2_va;
    assign bus.doutb  = s2_db;
    assign bus.validb = s2_vb;
  end else begin : g_lat1
    assign bus.douta  = s1_da;
    assign bus.valida = s1_va;
    assign bus.doutb  = s1_db;
    assign bus.validb = s1_vb;
  end

  assign bus.collision = coll_q;

endmodule

// File: tb/tb_dpram_pipe.sv
// Bench for dpram_pipe: two instances (RD_LAT=1/read-first/A-wins and RD_LAT=2/write-first/B-wins)
// share one directed stimulus stream and are checked every cycle against a queue-based model.
module tb_dpram_pipe;

  localparam int P_LAT [2] = '{1, 2};
  localparam int P_WM  [2] = '{0, 1};
  localparam int P_CP  [2] = '{0, 1};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dpram_pipe_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
  dpram_pipe_if #(.DATA_W(8), .ADDR_W(4)) if1 ();

  dpram_pipe #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1), .WR_MODE(0), .COLL_PRIO(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  dpram_pipe #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2), .WR_MODE(1), .COLL_PRIO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit run     = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [7:0] d; bit k; } rd_t;
  rd_t        pq [4][$];          // pending reads, index = dut*2 + port
  logic [7:0] mm [2][16];
  bit         kn [2][16];         // word has been written since time 0
  logic [7:0] ed [4];
  bit         ek [4];
  bit         ev [4];
  bit         ecoll [2];
  int         cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      pq[i].delete();
      ed[i] = 8'h00;
      ek[i] = 1'b1;
      ev[i] = 1'b0;
    end
    ecoll[0] = 1'b0;
    ecoll[1] = 1'b0;
  endtask

  task automatic model_step(input int d, input logic ea, wa, input logic [3:0] aa,
                            input logic [7:0] da, input logic eb, wb,
                            input logic [3:0] ab, input logic [7:0] db);
    rd_t e;
    logic [7:0] old_a, old_b;
    bit k_a, k_b, same;
    old_a = mm[d][aa]; k_a = kn[d][aa];
    old_b = mm[d][ab]; k_b = kn[d][ab];
    same  = (aa == ab);
    if (ea) begin
      e.due = cyc + P_LAT[d] - 1;
      e.d   = (wa && P_WM[d] == 1) ? da : old_a;
      e.k   = (wa && P_WM[d] == 1) ? 1'b1 : k_a;
      pq[d*2].push_back(e);
    end
    if (eb) begin
      e.due = cyc + P_LAT[d] - 1;
      e.d   = (wb && P_WM[d] == 1) ? db : old_b;
      e.k   = (wb && P_WM[d] == 1) ? 1'b1 : k_b;
      pq[d*2+1].push_back(e);
    end
    if (ea && wa && eb && wb && same) begin
      mm[d][aa] = (P_CP[d] == 1) ? db : da;
      kn[d][aa] = 1'b1;
    end else begin
      if (ea && wa) begin mm[d][aa] = da; kn[d][aa] = 1'b1; end
      if (eb && wb) begin mm[d][ab] = db; kn[d][ab] = 1'b1; end
    end
    ecoll[d] = ea && eb && same && (wa || wb);
    for (int p = 0; p < 2; p++) begin
      ev[d*2+p] = 1'b0;
      if (pq[d*2+p].size() > 0 && pq[d*2+p][0].due == cyc) begin
        e = pq[d*2+p].pop_front();
        ev[d*2+p] = 1'b1;
        ed[d*2+p] = e.d;
        ek[d*2+p] = e.k;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) kn[d][a] = 1'b0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        cyc++;
        model_step(0, if0.ena, if0.wea, if0.addra, if0.dina, if0.enb, if0.web, if0.addrb, if0.dinb);
        model_step(1, if1.ena, if1.wea, if1.addra, if1.dina, if1.enb, if1.web, if1.addrb, if1.dinb);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run) begin
      chk("u0.valida", {31'd0, if0.valida}, {31'd0, ev[0]});
      chk("u0.validb", {31'd0, if0.validb}, {31'd0, ev[1]});
      chk("u1.valida", {31'd0, if1.valida}, {31'd0, ev[2]});
      chk("u1.validb", {31'd0, if1.validb}, {31'd0, ev[3]});
      chk("u0.collision", {31'd0, if0.collision}, {31'd0, ecoll[0]});
      chk("u1.collision", {31'd0, if1.collision}, {31'd0, ecoll[1]});
      if (ek[0]) chk("u0.douta", {24'd0, if0.douta}, {24'd0, ed[0]});
      if (ek[1]) chk("u0.doutb", {24'd0, if0.doutb}, {24'd0, ed[1]});
      if (ek[2]) chk("u1.douta", {24'd0, if1.douta}, {24'd0, ed[2]});
      if (ek[3]) chk("u1.doutb", {24'd0, if1.doutb}, {24'd0, ed[3]});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic ea, wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic eb, wb, input logic [3:0] ab, input logic [7:0] db);
    @(posedge clk);
    #2;
    if0.ena = ea; if0.wea = wa; if0.addra = aa; if0.dina = da;
    if0.enb = eb; if0.web = wb; if0.addrb = ab; if0.dinb = db;
    if1.ena = ea; if1.wea = wa; if1.addra = aa; if1.dina = da;
    if1.enb = eb; if1.web = wb; if1.addrb = ab; if1.dinb = db;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic rd_a(input logic [3:0] a);
    drive(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    if0.ena = 0; if0.wea = 0; if0.addra = 0; if0.dina = 0;
    if0.enb = 0; if0.web = 0; if0.addrb = 0; if0.dinb = 0;
    if1.ena = 0; if1.wea = 0; if1.addra = 0; if1.dina = 0;
    if1.enb = 0; if1.web = 0; if1.addrb = 0; if1.dinb = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst u0.douta", {24'd0, if0.douta}, 32'h0);
    chk("rst u1.doutb", {24'd0, if1.doutb}, 32'h0);
    chk("rst u1.valida", {31'd0, if1.valida}, 32'h0);
    chk("rst u0.collision", {31'd0, if0.collision}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // fill: A writes 0..7 <- 10+i, B writes 8..15 <- 20+i
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 4'(i), 8'(8'h10 + i), 1'b1, 1'b1, 4'(i + 8), 8'(8'h20 + i));

    // 1: dual writes then dual reads
    drive(1'b1, 1'b1, 4'h3, 8'hA5, 1'b1, 1'b1, 4'h5, 8'h5A);
    drive(1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h5, 8'h00);
    idle();
    @(negedge clk);
    chk("t1 u0.douta", {24'd0, if0.douta}, 32'hA5);
    chk("t1 u0.doutb", {24'd0, if0.doutb}, 32'h5A);
    chk("t1 u0.valida", {31'd0, if0.valida}, 32'h1);
    idle();
    @(negedge clk);
    chk("t1 u0.valida once", {31'd0, if0.valida}, 32'h0);
    chk("t1 u0.douta hold", {24'd0, if0.douta}, 32'hA5);
    chk("t1 u1.doutb", {24'd0, if1.doutb}, 32'h5A);

    // 2: same-port read-during-write
    wr_a(4'h7, 8'h11);
    wr_a(4'h7, 8'h22);
    idle();
    @(negedge clk);
    chk("t2 u0.douta read-first", {24'd0, if0.douta}, 32'h11);
    idle();
    @(negedge clk);
    chk("t2 u1.douta write-first", {24'd0, if1.douta}, 32'h22);

    // 3: write-write collision
    drive(1'b1, 1'b1, 4'h9, 8'hAA, 1'b1, 1'b1, 4'h9, 8'hBB);
    idle();
    @(negedge clk);
    chk("t3 u0.collision", {31'd0, if0.collision}, 32'h1);
    chk("t3 u1.collision", {31'd0, if1.collision}, 32'h1);
    idle();
    @(negedge clk);
    chk("t3 collision once", {31'd0, if0.collision}, 32'h0);
    rd_a(4'h9);
    idle();
    @(negedge clk);
    chk("t3 u0 winner A", {24'd0, if0.douta}, 32'hAA);
    idle();
    @(negedge clk);
    chk("t3 u1 winner B", {24'd0, if1.douta}, 32'hBB);

    // 4: A reads while B writes the same address
    wr_a(4'h4, 8'h33);
    drive(1'b1, 1'b0, 4'h4, 8'h00, 1'b1, 1'b1, 4'h4, 8'h44);
    idle();
    @(negedge clk);
    chk("t4 u0.douta old", {24'd0, if0.douta}, 32'h33);
    chk("t4 u0.collision", {31'd0, if0.collision}, 32'h1);
    idle();
    @(negedge clk);
    chk("t4 u1.douta old", {24'd0, if1.douta}, 32'h33);
    rd_a(4'h4);
    idle();
    @(negedge clk);
    chk("t4 u0 reread", {24'd0, if0.douta}, 32'h44);

    // 5: back-to-back reads through the 2-stage pipeline
    rd_a(4'h0);
    rd_a(4'h1);
    rd_a(4'h2);
    @(negedge clk);
    chk("t5 u1 word0", {24'd0, if1.douta}, 32'h10);
    chk("t5 u1 valid0", {31'd0, if1.valida}, 32'h1);
    idle();
    @(negedge clk);
    chk("t5 u1 word1", {24'd0, if1.douta}, 32'h11);
    chk("t5 u1 valid1", {31'd0, if1.valida}, 32'h1);
    idle();
    @(negedge clk);
    chk("t5 u1 word2", {24'd0, if1.douta}, 32'h12);
    chk("t5 u1 valid2", {31'd0, if1.valida}, 32'h1);
    idle();
    @(negedge clk);
    chk("t5 u1 valid end", {31'd0, if1.valida}, 32'h0);

    // 6: reset between read edge and its output; write attempted during reset
    rd_a(4'h3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    if0.ena = 1; if0.wea = 1; if0.addra = 4'h3; if0.dina = 8'hFF;
    if1.ena = 1; if1.wea = 1; if1.addra = 4'h3; if1.dina = 8'hFF;
    @(negedge clk);
    chk("t6 u1.douta flushed", {24'd0, if1.douta}, 32'h0);
    chk("t6 u1.valida flushed", {31'd0, if1.valida}, 32'h0);
    chk("t6 u0.douta flushed", {24'd0, if0.douta}, 32'h0);
    idle();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 u1 no late valid", {31'd0, if1.valida}, 32'h0);
    rd_a(4'h3);
    idle();
    @(negedge clk);
    chk("t6 u0 preserved", {24'd0, if0.douta}, 32'hA5);
    idle();
    @(negedge clk);
    chk("t6 u1 preserved", {24'd0, if1.douta}, 32'hA5);

    // randomised-address independent traffic on different addresses
    for (int i = 0; i < 20; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 7));
      drive(1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
            1'b1, 1'($urandom_range(0, 1)), 4'(a + 8), 8'($urandom_range(0, 255)));
    end
    repeat (4) idle();
    @(negedge clk);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
